// File: rtl/div_rem_sched_pkg.sv
// Shared types for the mult/div functional unit.
// Divide scheduler entries, states and special-case decode.
package rv32i_types;

  localparam logic [2:0] mult_div_f3_mul    = 3'b000;
  localparam logic [2:0] mult_div_f3_mulh   = 3'b001;
  localparam logic [2:0] mult_div_f3_mulhsu = 3'b010;
  localparam logic [2:0] mult_div_f3_mulhu  = 3'b011;
  localparam logic [2:0] mult_div_f3_div    = 3'b100;
  localparam logic [2:0] mult_div_f3_divu   = 3'b101;
  localparam logic [2:0] mult_div_f3_rem    = 3'b110;
  localparam logic [2:0] mult_div_f3_remu   = 3'b111;

  localparam int NUM_DIV_CYCLES = 34;

  localparam int PD_BITS  = 6;
  localparam int ROB_BITS = 5;

  typedef struct packed {
    logic [31:0]         rs1_v;
    logic [31:0]         rs2_v;
    logic [2:0]          funct3;
    logic [PD_BITS-1:0]  pd;
    logic [ROB_BITS-1:0] rob;
  } div_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } div_special_t;

  function automatic logic div_f3_legal(
    input logic [2:0] f3
  );
    return (f3 == mult_div_f3_div)  ||
           (f3 == mult_div_f3_divu) ||
           (f3 == mult_div_f3_rem)  ||
           (f3 == mult_div_f3_remu);
  endfunction

  function automatic logic [32:0] div_ext(
    input logic [31:0] v,
    input logic        sgn
  );
    return {sgn & v[31], v};
  endfunction

  function automatic div_special_t div_special(
    input logic [31:0] rs1,
    input logic [31:0] rs2,
    input logic        is_rem,
    input logic        is_sgn
  );
    div_special_t s;
    s.hit = 1'b0;
    s.val = '0;
    unique case (1'b1)
      (rs2 == 32'h0): begin
        s.hit = 1'b1;
        s.val = is_rem ? rs1 : 32'hffff_ffff;
      end
      (is_sgn && rs1 == 32'h8000_0000 &&
       rs2 == 32'hffff_ffff): begin
        s.hit = 1'b1;
        s.val = is_rem ? 32'h0 : 32'h8000_0000;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/div_rem_sched_fifo.sv
// Small in-order queue of pending divide ops.
// Flush empties it and wins over a same-cycle push.
module fu_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  div_entry_t din,
  output div_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  div_entry_t     mem [DEPTH];
  logic [AW:0]    wp;
  logic [AW:0]    rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  // pointer update; flush drops queued and incoming work
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + (AW+1)'(1);
      if (pop && !empty)
        rp <= rp + (AW+1)'(1);
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/div_rem_sched.sv
// Issue controller and result buffer for the shared
// sequential divider: queue, special cases, CDB hold.
module div_rem_sched
  import rv32i_types::*;
#(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = PD_BITS,
  parameter int ROB_IDX_BITS  = ROB_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_rs1_v,
  input  logic [31:0]              req_rs2_v,
  input  logic [2:0]               req_funct3,
  input  logic [PHYS_REG_BITS-1:0] req_pd,
  input  logic [ROB_IDX_BITS-1:0]  req_rob,
  input  logic                     flush,
  output logic                     div_start,
  output logic [32:0]              div_a,
  output logic [32:0]              div_b,
  input  logic                     div_complete,
  input  logic [32:0]              div_quotient,
  input  logic [32:0]              div_remainder,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [31:0]              cdb_rd_v,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob,
  output logic                     busy
);

  sched_state_t state;
  div_entry_t   req_e;
  div_entry_t   head;
  div_entry_t   cur;
  div_special_t sp;
  logic         full;
  logic         empty;
  logic         pop;
  logic         issue;
  logic         cmp_q;
  logic         cmp_edge;
  logic         unused;

  assign req_e = '{
    rs1_v:  req_rs1_v,
    rs2_v:  req_rs2_v,
    funct3: req_funct3,
    pd:     PD_BITS'(req_pd),
    rob:    ROB_BITS'(req_rob)
  };

  fu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (pop),
    .flush (flush),
    .din   (req_e),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign sp = div_special(head.rs1_v, head.rs2_v,
                          head.funct3[1], !head.funct3[0]);

  assign pop       = (state == IDLE) && !empty && !flush;
  assign issue     = pop && !sp.hit;
  assign div_start = issue;
  assign cmp_edge  = div_complete && !cmp_q;
  assign req_ready = !full;
  assign busy      = (state != IDLE) || !empty;
  assign cdb_valid = (state == DONE);

  assign unused = ^{div_quotient[32], div_remainder[32],
                    cur.funct3[2]};

  // operands come from the head on issue, then from the
  // in-flight copy so the core sees them stable until done
  always_comb begin
    div_a = '0;
    div_b = '0;
    if (issue) begin
      div_a = div_ext(head.rs1_v, !head.funct3[0]);
      div_b = div_ext(head.rs2_v, !head.funct3[0]);
    end else if (state == RUN || state == DRAIN) begin
      div_a = div_ext(cur.rs1_v, !cur.funct3[0]);
      div_b = div_ext(cur.rs2_v, !cur.funct3[0]);
    end
  end

  // issue / wait / hold-for-CDB state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      cmp_q    <= 1'b0;
      cdb_rd_v <= '0;
      cdb_pd   <= '0;
      cdb_rob  <= '0;
    end else begin
      cmp_q <= div_complete;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (sp.hit) begin
              cdb_rd_v <= sp.val;
              cdb_pd   <= PHYS_REG_BITS'(head.pd);
              cdb_rob  <= ROB_IDX_BITS'(head.rob);
              state    <= DONE;
            end else begin
              cur   <= head;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            // a completion edge in the flush cycle means the
            // core is already idle, so nothing left to drain
            state <= cmp_edge ? IDLE : DRAIN;
          end else if (cmp_edge) begin
            cdb_rd_v <= cur.funct3[1] ? div_remainder[31:0]
                                      : div_quotient[31:0];
            cdb_pd   <= PHYS_REG_BITS'(cur.pd);
            cdb_rob  <= ROB_IDX_BITS'(cur.rob);
            state    <= DONE;
          end
        end
        DONE: begin
          if (flush || cdb_ready)
            state <= IDLE;
        end
        DRAIN: begin
          if (cmp_edge)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // only divide/remainder encodings may be dispatched here
  always_ff @(posedge clk) begin
    if (!rst && req_valid && req_ready)
      assert (div_f3_legal(req_funct3));
  end

endmodule

// File: tb/tb_div_rem_sched.sv
// Directed bench for div_rem_sched with a behavioural
// stand-in for the sequential divide core.
module tb_div_rem_sched;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs1_v;
  logic [31:0] req_rs2_v;
  logic [2:0]  req_funct3;
  logic [5:0]  req_pd;
  logic [4:0]  req_rob;
  logic        flush;
  logic        div_start;
  logic [32:0] div_a;
  logic [32:0] div_b;
  logic        div_complete;
  logic [32:0] div_quotient;
  logic [32:0] div_remainder;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [31:0] cdb_rd_v;
  logic [5:0]  cdb_pd;
  logic [4:0]  cdb_rob;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cnt;

  div_rem_sched #(
    .DEPTH(4), .PHYS_REG_BITS(6), .ROB_IDX_BITS(5)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_v(req_rs1_v), .req_rs2_v(req_rs2_v),
    .req_funct3(req_funct3),
    .req_pd(req_pd), .req_rob(req_rob),
    .flush(flush),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_complete(div_complete),
    .div_quotient(div_quotient),
    .div_remainder(div_remainder),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rd_v(cdb_rd_v), .cdb_pd(cdb_pd),
    .cdb_rob(cdb_rob), .busy(busy)
  );

  always #5 clk = ~clk;

  // divide core stand-in: complete rises NUM_DIV_CYCLES
  // after start and stays high until the next start
  always @(posedge clk) begin
    if (rst) begin
      cnt           <= 0;
      div_complete  <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      cnt           <= NUM_DIV_CYCLES - 1;
      div_complete  <= 1'b0;
      div_quotient  <= $signed(div_a) / $signed(div_b);
      div_remainder <= $signed(div_a) % $signed(div_b);
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1)
        div_complete <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [2:0]  f,
                     input int          tag);
    req_valid  = 1'b1;
    req_rs1_v  = a;
    req_rs2_v  = b;
    req_funct3 = f;
    req_pd     = 6'(tag);
    req_rob    = 5'(tag + 10);
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic wait_cdb(output int n);
    n = 0;
    while (!cdb_valid && n < 200) begin
      tick();
      n++;
    end
    if (!cdb_valid)
      chk("cdb_timeout", 64'(0), 64'(1));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  vec_t vecs [12] = '{
    '{32'd100,       32'd7,         mult_div_f3_div,
      32'd14,        1'b0},
    '{32'd100,       32'd7,         mult_div_f3_rem,
      32'd2,         1'b0},
    '{32'hffffff9c,  32'd7,         mult_div_f3_div,
      32'hfffffff2,  1'b0},
    '{32'hffffff9c,  32'd7,         mult_div_f3_rem,
      32'hfffffffe,  1'b0},
    '{32'hffffffff,  32'd2,         mult_div_f3_divu,
      32'h7fffffff,  1'b0},
    '{32'hffffffff,  32'd10,        mult_div_f3_remu,
      32'd5,         1'b0},
    '{32'h80000000,  32'hffffffff,  mult_div_f3_div,
      32'h80000000,  1'b1},
    '{32'h80000000,  32'hffffffff,  mult_div_f3_rem,
      32'd0,         1'b1},
    '{32'd5,         32'd0,         mult_div_f3_divu,
      32'hffffffff,  1'b1},
    '{32'd5,         32'd0,         mult_div_f3_remu,
      32'd5,         1'b1},
    '{32'd7,         32'd0,         mult_div_f3_div,
      32'hffffffff,  1'b1},
    '{32'h80000000,  32'hffffffff,  mult_div_f3_divu,
      32'd0,         1'b0}
  };

  logic [31:0] fill_exp [5] = '{
    32'd33, 32'd66, 32'd100, 32'd133, 32'd166
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          seen;
    logic [32:0] ea;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_rs1_v  = '0;
    req_rs2_v  = '0;
    req_funct3 = mult_div_f3_div;
    req_pd     = '0;
    req_rob    = '0;
    flush      = 1'b0;
    cdb_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_start", 64'(div_start), 64'(0));
    chk("rst_rd",    64'(cdb_rd_v),  64'(0));

    // single ops, normal and special
    foreach (vecs[i]) begin
      enq(vecs[i].a, vecs[i].b, vecs[i].f, i);
      chk("start", 64'(div_start), 64'(!vecs[i].sp));
      if (!vecs[i].sp) begin
        ea = {vecs[i].a[31] & !vecs[i].f[0], vecs[i].a};
        chk("div_a", 64'(div_a), 64'(ea));
      end
      wait_cdb(n);
      chk("latency", 64'(n),
          64'(vecs[i].sp ? 1 : NUM_DIV_CYCLES + 1));
      chk("rd_v", 64'(cdb_rd_v), 64'(vecs[i].exp));
      chk("pd",   64'(cdb_pd),   64'(i));
      chk("rob",  64'(cdb_rob),  64'(i + 10));
      cdb_ready = 1'b1;
      tick();
      cdb_ready = 1'b0;
      chk("valid_drop", 64'(cdb_valid), 64'(0));
    end

    // fill the queue while the CDB is stalled
    for (int k = 0; k < 5; k++) begin
      chk("rdy_push", 64'(req_ready), 64'(1));
      req_valid  = 1'b1;
      req_rs1_v  = 32'(100 * (k + 1));
      req_rs2_v  = 32'd3;
      req_funct3 = mult_div_f3_divu;
      req_pd     = 6'(k);
      req_rob    = 5'(20 + k);
      tick();
    end
    req_rs1_v = 32'd999;
    chk("rdy_full", 64'(req_ready), 64'(0));
    tick();
    req_valid = 1'b0;
    cdb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_cdb(n);
      chk("fill_rd",  64'(cdb_rd_v), 64'(fill_exp[k]));
      chk("fill_rob", 64'(cdb_rob),  64'(20 + k));
      tick();
    end
    chk("fill_idle", 64'(busy), 64'(0));
    cdb_ready = 1'b0;

    // flush while running with two queued
    enq(32'd50, 32'd5, mult_div_f3_div, 1);
    enq(32'd60, 32'd5, mult_div_f3_div, 2);
    enq(32'd70, 32'd5, mult_div_f3_div, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy",  64'(busy),      64'(1));
    chk("drain_ready", 64'(req_ready), 64'(1));
    seen = 0;
    n    = 0;
    while (busy && n < 200) begin
      if (cdb_valid || div_start)
        seen++;
      tick();
      n++;
    end
    chk("drain_quiet", 64'(seen), 64'(0));
    chk("drain_len",   64'(n),    64'(NUM_DIV_CYCLES - 2));
    enq(32'd1000, 32'hfffffff6, mult_div_f3_div, 4);
    chk("post_start", 64'(div_start), 64'(1));
    wait_cdb(n);
    chk("post_rd", 64'(cdb_rd_v), 64'(32'hffffff9c));
    chk("post_pd", 64'(cdb_pd),   64'(4));
    cdb_ready = 1'b1;
    tick();
    cdb_ready = 1'b0;

    // flush with enqueue and CDB grant while in DONE
    enq(32'd5, 32'd0, mult_div_f3_divu, 5);
    tick();
    chk("done_valid", 64'(cdb_valid), 64'(1));
    flush      = 1'b1;
    cdb_ready  = 1'b1;
    req_valid  = 1'b1;
    req_rs1_v  = 32'd9;
    req_rs2_v  = 32'd3;
    req_funct3 = mult_div_f3_div;
    tick();
    flush     = 1'b0;
    cdb_ready = 1'b0;
    req_valid = 1'b0;
    chk("fl_valid", 64'(cdb_valid), 64'(0));
    chk("fl_busy",  64'(busy),      64'(0));
    chk("fl_start", 64'(div_start), 64'(0));
    tick();
    chk("fl_valid2", 64'(cdb_valid), 64'(0));

    // reset in the middle of a divide
    enq(32'd100, 32'd7, mult_div_f3_div, 6);
    tick();
    tick();
    chk("run_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    chk("mr_valid", 64'(cdb_valid), 64'(0));
    chk("mr_rd",    64'(cdb_rd_v),  64'(0));
    chk("mr_pd",    64'(cdb_pd),    64'(0));
    chk("mr_rob",   64'(cdb_rob),   64'(0));
    chk("mr_start", 64'(div_start), 64'(0));
    chk("mr_a",     64'(div_a),     64'(0));
    chk("mr_b",     64'(div_b),     64'(0));
    chk("mr_busy",  64'(busy),      64'(0));
    chk("mr_ready", 64'(req_ready), 64'(1));
    rst = 1'b0;
    tick();
    enq(32'd17, 32'd5, mult_div_f3_remu, 7);
    wait_cdb(n);
    chk("rec_rd",  64'(cdb_rd_v), 64'(2));
    chk("rec_rob", 64'(cdb_rob),  64'(17));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_rem_sched.md
# div_rem_sched

Issue controller and result buffer for the shared sequential divider in the mult/div functional unit. It accepts DIV/DIVU/REM/REMU operations from the dispatch path into a small FIFO and issues them one at a time to the 33-bit sequential divide core. Divide-by-zero and signed-overflow cases are resolved without the core, per RISC-V semantics. Each result is held until the CDB accepts it, and a global branch flush squashes all queued and in-flight work.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PHYS_REG_BITS, 6: physical destination tag width.
- ROB_IDX_BITS, 5: ROB index width.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  dispatch offers a div/rem op
- req_ready  out  1  FIFO not full
- req_rs1_v, req_rs2_v  in  32  dividend, divisor
- req_funct3  in  3  mult_div_f3_div/divu/rem/remu only
- req_pd  in  PHYS_REG_BITS  destination physical register
- req_rob  in  ROB_IDX_BITS  ROB index
- flush  in  1  global branch signal
- div_start  out  1  one-cycle start pulse to the divide core
- div_a, div_b  out  33  extended operands; held stable from start to complete
- div_complete  in  1  core complete (level, per the core)
- div_quotient, div_remainder  in  33  core results
- cdb_valid  out  1  result available
- cdb_ready  in  1  CDB grant
- cdb_rd_v  out  32  result value
- cdb_pd, cdb_rob  out  tag widths  result tags
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- **Enqueue.** An op enters the FIFO when req_valid and req_ready are both high.
  - req_ready is !full and does not account for a same-cycle pop.
  - A req_funct3 outside div/divu/rem/remu is illegal; an assertion fires.
- **Extension.** DIV and REM sign-extend both operands to 33 bits. DIVU and REMU zero-extend.
- **Special cases** (decided at issue, core not started):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; the same operands under REM give 0.
- **Normal result.** DIV/DIVU give quotient[31:0]; REM/REMU give remainder[31:0].
- **FSM states:** IDLE, RUN, DONE, DRAIN.
  - IDLE, head is special: compute the result into the output register, pop the head, go to DONE.
  - IDLE, head is normal: drive div_a/div_b from the head, pulse div_start, pop the head into the in-flight register, go to RUN.
  - RUN: on the first cycle div_complete is high, latch the result and tags, go to DONE. Only the rising edge of complete counts: a complete that was already high on the cycle of div_start is ignored.
  - DONE: cdb_valid=1. On cdb_ready, go to IDLE.
  - DRAIN: wait for the completion edge, discard the result, go to IDLE.
- **Flush** takes priority over every other event in the same cycle:
  - The FIFO empties, and a same-cycle enqueue is dropped.
  - RUN goes to DRAIN. DONE and IDLE go to IDLE with no CDB output.
  - A flush arriving while in DRAIN keeps the FSM in DRAIN.
- **Reset.** FSM to IDLE, FIFO empty, all outputs 0; req_ready is 1 from the first cycle after reset. Reset mid-operation abandons all state. The core is reset by the same rst.
- **Outputs.** cdb_rd_v, cdb_pd and cdb_rob are registered and stable while cdb_valid is high and the CDB has not accepted.

## Timing
- Enqueue at cycle t makes the entry visible at t+1; IDLE issues at t+1 (div_start high in t+1).
- Normal op: div_complete is seen at t+1+NUM_DIV_CYCLES, and cdb_valid rises the following cycle.
- Special op: cdb_valid rises at t+2.
- DONE with cdb_ready high in the first DONE cycle returns to IDLE next cycle, so back-to-back issue has one IDLE cycle between ops.
- Occupancy is at most one op in flight plus DEPTH queued.

## Structure
- The package (rv32i_types) holds:
  - the mult_div funct3 encodings;
  - NUM_DIV_CYCLES;
  - a div_entry_t struct {rs1_v, rs2_v, funct3, pd, rob};
  - a sched state enum.
- Sub-module: fu_fifo (DEPTH × div_entry_t, push/pop/flush, full/empty), used for the queue.
- The special-case decode is a function in the package.

## Test plan
- 100 / 7 DIV, then REM → cdb_rd_v 14 then 2, cdb_valid one cycle after the completion edge; tags match.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at t+2, div_start never pulses; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Push 5 ops with cdb_ready held low → req_ready falls after the 4th queued. Release cdb_ready → in-order results.
- Flush in RUN with 2 queued → FSM in DRAIN, no cdb_valid. The next op enqueued after the core completes returns a correct result.
- Flush coincident with req_valid and with cdb_ready in DONE → the enqueue is dropped and no result is emitted.
- Reset asserted mid-RUN → all outputs 0 next cycle, busy 0, req_ready 1.
